// File: rtl/pid_pkg.sv
// Shared definitions for the sequential PID loop.
// Holds the FSM state encoding, the default parameter values and a small
// width helper used when sizing intermediate sums.
package pid_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_CW   = 8;
    localparam int DEF_FRAC = 4;
    localparam int DEF_IW   = 20;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERR  = 3'd1,
        S_MP   = 3'd2,
        S_MI   = 3'd3,
        S_MD   = 3'd4,
        S_SUM  = 3'd5
    } pid_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed saturating narrower.
// Ports:
//   din  - signed IN_W-bit value to clip
//   dout - din clipped to the signed OUT_W-bit range
//   clip - 1 when din was outside that range
// IN_W must be >= OUT_W.
module pid_sat
    import pid_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Compare against the output range limits and pick limit or passthrough.
    always_comb begin
        dout = din[OUT_W-1:0];
        clip = 1'b0;
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
            clip = 1'b1;
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
            clip = 1'b1;
        end else begin
            dout = din[OUT_W-1:0];
            clip = 1'b0;
        end
    end

endmodule

// File: rtl/pid_loop_seq.sv
// Sequential PID controller with one shared multiplier.
// A sample is taken in IDLE, then ERR, MP, MI, MD and SUM each take one
// clock; the saturated control value is registered on the SUM->IDLE edge.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - sample handshake (ready only in IDLE)
//   setpoint, feedback   - signed DW-bit inputs
//   kp, ki, kd           - unsigned CW-bit gains, Q(CW-FRAC).FRAC
//   clear                - synchronous loop-state clear, aborts any result
//   out_valid            - one-cycle result strobe
//   control, sat         - signed saturated output and its clip flag
module pid_loop_seq
    import pid_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CW   = DEF_CW,
    parameter int FRAC = DEF_FRAC,
    parameter int IW   = DEF_IW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] setpoint,
    input  logic signed [DW-1:0] feedback,
    input  logic [CW-1:0]        kp,
    input  logic [CW-1:0]        ki,
    input  logic [CW-1:0]        kd,
    input  logic                 clear,
    output logic                 out_valid,
    output logic signed [DW-1:0] control,
    output logic                 sat
);

    localparam int EW    = DW + 1;               // error width
    localparam int AW    = DW + 2;               // multiplier data operand (fits error delta)
    localparam int BW    = CW + 1;               // multiplier gain operand (zero-extended)
    localparam int PW    = AW + BW;              // product width
    localparam int IS_W  = max_int(IW, PW) + 1;  // integrator pre-saturation sum
    localparam int SUM_W = max_int(IW, PW) + 2;  // three-term sum, cannot overflow

    pid_state_e            state_r;
    logic                  in_ready_r;
    logic signed [DW-1:0]  sp_r;
    logic signed [DW-1:0]  fb_r;
    logic [CW-1:0]         kp_r;
    logic [CW-1:0]         ki_r;
    logic [CW-1:0]         kd_r;
    logic signed [EW-1:0]  err_r;
    logic signed [EW-1:0]  prev_err_r;
    logic                  prev_valid_r;
    logic signed [PW-1:0]  p_r;
    logic signed [PW-1:0]  d_r;
    logic signed [IW-1:0]  integ_r;
    logic signed [DW-1:0]  control_r;
    logic                  sat_r;
    logic                  out_valid_r;

    logic signed [AW-1:0]    mul_a_s;
    logic signed [BW-1:0]    mul_b_s;
    logic signed [PW-1:0]    product_s;
    logic signed [IS_W-1:0]  integ_sum_s;
    logic signed [IW-1:0]    integ_next_s;
    logic                    integ_clip_unused_s;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [DW-1:0]    ctrl_next_s;
    logic                    ctrl_clip_s;
    logic                    windup_hold_s;

    // Route the operands of the single shared multiplier by FSM state.
    always_comb begin
        mul_a_s = {AW{1'b0}};
        mul_b_s = {BW{1'b0}};
        case (state_r)
            S_MP: begin
                mul_a_s = AW'(err_r);
                mul_b_s = {1'b0, kp_r};
            end
            S_MI: begin
                mul_a_s = AW'(err_r);
                mul_b_s = {1'b0, ki_r};
            end
            S_MD: begin
                // Without a valid previous error the derivative term is zero.
                if (prev_valid_r) begin
                    mul_a_s = AW'(err_r) - AW'(prev_err_r);
                end else begin
                    mul_a_s = {AW{1'b0}};
                end
                mul_b_s = {1'b0, kd_r};
            end
            default: begin
                mul_a_s = {AW{1'b0}};
                mul_b_s = {BW{1'b0}};
            end
        endcase
    end

    assign product_s   = mul_a_s * mul_b_s;
    assign integ_sum_s = IS_W'(integ_r) + IS_W'(product_s);
    assign sum_s       = SUM_W'(p_r >>> FRAC) + SUM_W'(integ_r >>> FRAC) + SUM_W'(d_r >>> FRAC);

    // Anti-windup: while the output is clipped, an error pushing further in
    // the clipped direction must not grow the integrator.
    assign windup_hold_s = sat_r && (err_r[EW-1] == control_r[DW-1]);

    pid_sat #(.IN_W(IS_W), .OUT_W(IW)) u_integ_sat (
        .din  (integ_sum_s),
        .dout (integ_next_s),
        .clip (integ_clip_unused_s)
    );

    pid_sat #(.IN_W(SUM_W), .OUT_W(DW)) u_ctrl_sat (
        .din  (sum_s),
        .dout (ctrl_next_s),
        .clip (ctrl_clip_s)
    );

    // FSM sequencing, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            in_ready_r   <= 1'b1;
            sp_r         <= {DW{1'b0}};
            fb_r         <= {DW{1'b0}};
            kp_r         <= {CW{1'b0}};
            ki_r         <= {CW{1'b0}};
            kd_r         <= {CW{1'b0}};
            err_r        <= {EW{1'b0}};
            prev_err_r   <= {EW{1'b0}};
            prev_valid_r <= 1'b0;
            p_r          <= {PW{1'b0}};
            d_r          <= {PW{1'b0}};
            integ_r      <= {IW{1'b0}};
            control_r    <= {DW{1'b0}};
            sat_r        <= 1'b0;
            out_valid_r  <= 1'b0;
        end else if (clear) begin
            // Clear wins over acceptance; control keeps its last value.
            state_r      <= S_IDLE;
            in_ready_r   <= 1'b1;
            integ_r      <= {IW{1'b0}};
            prev_valid_r <= 1'b0;
            sat_r        <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        sp_r       <= setpoint;
                        fb_r       <= feedback;
                        kp_r       <= kp;
                        ki_r       <= ki;
                        kd_r       <= kd;
                        in_ready_r <= 1'b0;
                        state_r    <= S_ERR;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= S_IDLE;
                    end
                end
                S_ERR: begin
                    err_r   <= EW'(sp_r) - EW'(fb_r);
                    state_r <= S_MP;
                end
                S_MP: begin
                    p_r     <= product_s;
                    state_r <= S_MI;
                end
                S_MI: begin
                    if (!windup_hold_s) begin
                        integ_r <= integ_next_s;
                    end else begin
                        integ_r <= integ_r;
                    end
                    state_r <= S_MD;
                end
                S_MD: begin
                    d_r          <= product_s;
                    prev_err_r   <= err_r;
                    prev_valid_r <= 1'b1;
                    state_r      <= S_SUM;
                end
                S_SUM: begin
                    control_r   <= ctrl_next_s;
                    sat_r       <= ctrl_clip_s;
                    out_valid_r <= 1'b1;
                    in_ready_r  <= 1'b1;
                    state_r     <= S_IDLE;
                end
                default: begin
                    in_ready_r <= 1'b1;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign control   = control_r;
    assign sat       = sat_r;

endmodule

// File: tb/tb_pid_loop_seq.sv
// Self-checking bench for pid_loop_seq (DW=8, CW=8, FRAC=4, IW=20).
// Expected results are queued when a sample is driven and popped when the
// DUT strobes out_valid. A behavioural model supplies expectations for
// random samples; directed scenarios use hand-derived constants.
module tb_pid_loop_seq;

    localparam int IMAX = 524287;
    localparam int IMIN = -524288;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] setpoint;
    logic signed [7:0] feedback;
    logic [7:0]        kp, ki, kd;
    logic              clear;
    logic              out_valid;
    logic signed [7:0] control;
    logic              sat;

    always #5 clk = ~clk;

    pid_loop_seq #(.DW(8), .CW(8), .FRAC(4), .IW(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .setpoint  (setpoint),
        .feedback  (feedback),
        .kp        (kp),
        .ki        (ki),
        .kd        (kd),
        .clear     (clear),
        .out_valid (out_valid),
        .control   (control),
        .sat       (sat)
    );

    typedef struct {int c; bit s;} exp_t;
    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural loop state.
    int m_integ, m_prev, m_ctrl;
    bit m_pv, m_sat;

    task automatic model_reset(input bit hard);
        m_integ = 0;
        m_pv    = 1'b0;
        m_sat   = 1'b0;
        if (hard) m_ctrl = 0;
    endtask

    task automatic model_step(input int sp, input int fb, input int gp, input int gi, input int gd);
        int err, p, d, s;
        err = sp - fb;
        p   = gp * err;
        d   = m_pv ? gd * (err - m_prev) : 0;
        if (!(m_sat && ((err < 0) == (m_ctrl < 0)))) begin
            m_integ = m_integ + gi * err;
            if (m_integ > IMAX) m_integ = IMAX;
            if (m_integ < IMIN) m_integ = IMIN;
        end
        m_prev = err;
        m_pv   = 1'b1;
        s = (p >>> 4) + (m_integ >>> 4) + (d >>> 4);
        if (s > 127) begin
            m_ctrl = 127;  m_sat = 1'b1;
        end else if (s < -128) begin
            m_ctrl = -128; m_sat = 1'b1;
        end else begin
            m_ctrl = s;    m_sat = 1'b0;
        end
    endtask

    // Offer one sample, scramble inputs after acceptance, wait (bounded) for out_valid.
    // lat counts negedges after the accepting edge; 6 means visible to a
    // consumer sampling at the 6th edge after acceptance.
    task automatic drive_sample(input int sp, input int fb, input int gp, input int gi, input int gd,
                                input bit use_model, output bit got, output int lat,
                                output int c, output bit s, output bit rdy, output bit extra);
        @(negedge clk);
        setpoint = 8'(sp); feedback = 8'(fb);
        kp = 8'(gp); ki = 8'(gi); kd = 8'(gd);
        in_valid = 1'b1;
        model_step(sp, fb, gp, gi, gd);
        if (use_model) exp_q.push_back(exp_t'{m_ctrl, m_sat});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        setpoint = 8'($urandom); feedback = 8'($urandom);
        kp = 8'($urandom); ki = 8'($urandom); kd = 8'($urandom);
        got = 1'b0; lat = 0; c = 0; s = 1'b0; rdy = 1'b0; extra = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (i > 1) @(negedge clk);
            if (out_valid) begin
                got = 1'b1; lat = i; c = control; s = sat; rdy = in_ready;
            end
        end
        if (got) begin
            @(negedge clk);
            extra = out_valid;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset(1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        setpoint = '0; feedback = '0; kp = '0; ki = '0; kd = '0;
        model_reset(1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (control === 8'sd0) n_pass++; else $display("FAIL reset control: got %0d want 0", control);
        n_total++; if (sat === 1'b0) n_pass++; else $display("FAIL reset sat: got %0b want 0", sat);
        n_total++; if (out_valid === 1'b0) n_pass++; else $display("FAIL reset out_valid: got %0b want 0", out_valid);
        n_total++; if (in_ready === 1'b1) n_pass++; else $display("FAIL reset in_ready: got %0b want 1", in_ready);
    endtask

    task automatic test_proportional();
        int sps[2] = '{50, 127};
        int fbs[2] = '{20, -128};
        int ec[2]  = '{30, 127};
        bit es[2]  = '{1'b0, 1'b1};
        bit got, s, rdy, extra; int lat, c; exp_t e;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_t'{ec[i], es[i]});
            drive_sample(sps[i], fbs[i], 16, 0, 0, 1'b0, got, lat, c, s, rdy, extra);
            e = exp_q.pop_front();
            n_total++; if (got && c == e.c) n_pass++; else $display("FAIL prop[%0d] control: got %0d (strobe %0b) want %0d", i, c, got, e.c);
            n_total++; if (got && s == e.s) n_pass++; else $display("FAIL prop[%0d] sat: got %0b want %0b", i, s, e.s);
            n_total++; if (lat == 6) n_pass++; else $display("FAIL prop[%0d] latency: got %0d want 6", i, lat);
            n_total++; if (got && rdy) n_pass++; else $display("FAIL prop[%0d] in_ready at strobe: got %0b want 1", i, rdy);
            n_total++; if (got && !extra) n_pass++; else $display("FAIL prop[%0d] strobe width: second cycle %0b want 0", i, extra);
        end
    endtask

    task automatic test_clear_mid();
        bit got, s, rdy, extra; int lat, c, held; exp_t e;
        held = m_ctrl;
        @(negedge clk);
        setpoint = 8'sd10; feedback = 8'sd0; kp = 8'd0; ki = 8'd8; kd = 8'd0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);          // FSM now in MD
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_reset(1'b0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) got = 1'b1;
            @(negedge clk);
        end
        n_total++; if (!got) n_pass++; else $display("FAIL clear_mid aborted strobe: got out_valid want none");
        n_total++; if (control == held) n_pass++; else $display("FAIL clear_mid control held: got %0d want %0d", control, held);
        n_total++; if (sat === 1'b0) n_pass++; else $display("FAIL clear_mid sat: got %0b want 0", sat);
        exp_q.push_back(exp_t'{5, 1'b0});
        drive_sample(10, 0, 0, 8, 0, 1'b0, got, lat, c, s, rdy, extra);
        e = exp_q.pop_front();
        n_total++; if (got && c == e.c) n_pass++; else $display("FAIL clear_mid next control: got %0d (strobe %0b) want %0d", c, got, e.c);
    endtask

    task automatic test_integral();
        int ec[3] = '{5, 10, 15};
        bit got, s, rdy, extra; int lat, c; exp_t e;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exp_t'{ec[i], 1'b0});
            drive_sample(10, 0, 0, 8, 0, 1'b0, got, lat, c, s, rdy, extra);
            e = exp_q.pop_front();
            n_total++; if (got && c == e.c) n_pass++; else $display("FAIL integral[%0d] control: got %0d (strobe %0b) want %0d", i, c, got, e.c);
            n_total++; if (got && s == e.s) n_pass++; else $display("FAIL integral[%0d] sat: got %0b want %0b", i, s, e.s);
        end
    endtask

    task automatic test_derivative();
        int errs[2] = '{10, 30};
        int ec[2]   = '{0, 20};
        bit got, s, rdy, extra; int lat, c; exp_t e;
        do_clear();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_t'{ec[i], 1'b0});
            drive_sample(errs[i], 0, 0, 0, 16, 1'b0, got, lat, c, s, rdy, extra);
            e = exp_q.pop_front();
            n_total++; if (got && c == e.c) n_pass++; else $display("FAIL deriv[%0d] control: got %0d (strobe %0b) want %0d", i, c, got, e.c);
        end
    endtask

    task automatic test_anti_windup();
        // Integrator: 1600, 3200, held, held, 3040, 1440 -> control 100,127,127,127,127,90.
        int errs[6] = '{100, 100, 100, 100, -10, -100};
        int ec[6]   = '{100, 127, 127, 127, 127, 90};
        bit es[6]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit got, s, rdy, extra; int lat, c; exp_t e;
        do_clear();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exp_t'{ec[i], es[i]});
            drive_sample(errs[i], 0, 0, 16, 0, 1'b0, got, lat, c, s, rdy, extra);
            e = exp_q.pop_front();
            n_total++; if (got && c == e.c) n_pass++; else $display("FAIL windup[%0d] control: got %0d (strobe %0b) want %0d", i, c, got, e.c);
            n_total++; if (got && s == e.s) n_pass++; else $display("FAIL windup[%0d] sat: got %0b want %0b", i, s, e.s);
        end
    endtask

    task automatic test_reset_mid();
        bit got, s, rdy, extra; int lat, c; exp_t e;
        @(negedge clk);
        setpoint = 8'sd10; feedback = 8'sd0; kp = 8'd0; ki = 8'd8; kd = 8'd0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);          // FSM now in MD
        rst_n = 1'b0;
        model_reset(1'b1);
        #1;
        n_total++; if (control === 8'sd0 && sat === 1'b0 && out_valid === 1'b0) n_pass++;
        else $display("FAIL reset_mid outputs: control %0d sat %0b out_valid %0b want 0 0 0", control, sat, out_valid);
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_total++; if (in_ready === 1'b1) n_pass++; else $display("FAIL reset_mid in_ready after release: got %0b want 1", in_ready);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        n_total++; if (!got) n_pass++; else $display("FAIL reset_mid aborted strobe: got out_valid want none");
        exp_q.push_back(exp_t'{5, 1'b0});
        drive_sample(10, 0, 0, 8, 0, 1'b0, got, lat, c, s, rdy, extra);
        e = exp_q.pop_front();
        n_total++; if (got && c == e.c) n_pass++; else $display("FAIL reset_mid next control: got %0d (strobe %0b) want %0d", c, got, e.c);
    endtask

    task automatic test_clear_priority();
        bit got;
        @(negedge clk);
        setpoint = 8'sd40; feedback = 8'sd0; kp = 8'd16; ki = 8'd0; kd = 8'd0;
        in_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        model_reset(1'b0);
        n_total++; if (in_ready === 1'b1) n_pass++; else $display("FAIL clear_prio in_ready: got %0b want 1", in_ready);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        n_total++; if (!got) n_pass++; else $display("FAIL clear_prio dropped sample: got out_valid want none");
    endtask

    task automatic test_back_to_back();
        bit got, s, rdy, extra; int lat, c; exp_t e;
        int sp, fb, gp, gi, gd;
        do_clear();
        for (int i = 0; i < 10; i++) begin
            sp = int'($urandom_range(255)) - 128;
            fb = int'($urandom_range(255)) - 128;
            gp = int'($urandom_range(255));
            gi = int'($urandom_range(255));
            gd = int'($urandom_range(255));
            drive_sample(sp, fb, gp, gi, gd, 1'b1, got, lat, c, s, rdy, extra);
            e = exp_q.pop_front();
            n_total++; if (got && c == e.c) n_pass++; else $display("FAIL b2b[%0d] control: got %0d (strobe %0b) want %0d", i, c, got, e.c);
            n_total++; if (got && s == e.s) n_pass++; else $display("FAIL b2b[%0d] sat: got %0b want %0b", i, s, e.s);
            n_total++; if (lat == 6) n_pass++; else $display("FAIL b2b[%0d] latency: got %0d want 6", i, lat);
        end
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_clear_mid();
        test_integral();
        test_derivative();
        test_anti_windup();
        test_reset_mid();
        test_clear_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
